// File: rtl/paddle_position_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_position_ctrl
//   Bounded horizontal paddle position with hold-to-accelerate motion.
//   Button levels are decoded into a left/right/none request. The position is
//   updated only on a frame tick. The step size grows by one after every
//   ACCEL_TICKS moves made at the same step, and saturates at STEP_MAX. The
//   step falls back to STEP_BASE on release, on reversal, and when the paddle
//   hits a wall.
//
//   Optional build macro: PADDLE_WRAP_EN
//     When defined, an overshoot wraps to the opposite bound instead of
//     clamping. A wrap keeps the current step and hold count.
//
// Ports
//   clk      in   1  system clock
//   clr      in   1  asynchronous active-high reset
//   tick     in   1  frame update strobe (registers hold while low)
//   bL       in   1  move-left request level
//   bR       in   1  move-right request level
//   bar_pos  out  W  current position (registered)
//   step     out  W  step applied on the next continuing move (registered)
//   moving   out  1  FSM is in MOVE_L or MOVE_R
//   at_min   out  1  bar_pos == POS_MIN (registered)
//   at_max   out  1  bar_pos == POS_MAX (registered)
// ---------------------------------------------------------------------------
module paddle_position_ctrl #(
  parameter int W           = 7,
  parameter int POS_MIN     = 19,
  parameter int POS_MAX     = 67,
  parameter int POS_INIT    = 43,
  parameter int STEP_BASE   = 2,
  parameter int STEP_MAX    = 6,
  parameter int ACCEL_TICKS = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         tick,
  input  logic         bL,
  input  logic         bR,
  output logic [W-1:0] bar_pos,
  output logic [W-1:0] step,
  output logic         moving,
  output logic         at_min,
  output logic         at_max
);

  localparam int HW = $clog2(ACCEL_TICKS);

  localparam logic [W-1:0]  MIN_W     = W'(POS_MIN);
  localparam logic [W-1:0]  MAX_W     = W'(POS_MAX);
  localparam logic [W-1:0]  INIT_W    = W'(POS_INIT);
  localparam logic [W-1:0]  BASE_W    = W'(STEP_BASE);
  localparam logic [W-1:0]  SMAX_W    = W'(STEP_MAX);
  localparam logic [W:0]    MIN_E     = (W+1)'(POS_MIN);
  localparam logic [W:0]    MAX_E     = (W+1)'(POS_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [W-1:0]  pos_nxt, step_nxt, eff_step;
  logic [W:0]    diff, sum;
  logic          req_l, req_r, continuing, overshoot;

  function automatic logic [W-1:0] sat_step_inc(input logic [W-1:0] s);
    if (s >= SMAX_W) return SMAX_W;
    return s + W'(1);
  endfunction

  // Register stage: everything advances only on a frame tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      bar_pos  <= INIT_W;
      step     <= BASE_W;
      hold_cnt <= '0;
      at_min   <= (INIT_W == MIN_W);
      at_max   <= (INIT_W == MAX_W);
    end else if (tick) begin
      state    <= state_nxt;
      bar_pos  <= pos_nxt;
      step     <= step_nxt;
      hold_cnt <= hold_nxt;
      at_min   <= (pos_nxt == MIN_W);
      at_max   <= (pos_nxt == MAX_W);
    end
  end

  assign moving = (state == MOVE_L) || (state == MOVE_R);

  always_comb begin
    state_nxt  = state;
    pos_nxt    = bar_pos;
    step_nxt   = step;
    hold_nxt   = hold_cnt;
    eff_step   = BASE_W;
    continuing = 1'b0;
    overshoot  = 1'b0;
    req_l      = bL & ~bR;
    req_r      = bR & ~bL;
    // Both paths are computed one bit wider so nothing wraps before the
    // bound comparison.
    diff       = {1'b0, bar_pos} - {1'b0, eff_step};
    sum        = {1'b0, bar_pos} + {1'b0, eff_step};

    if (!req_l && !req_r) begin
      state_nxt = IDLE;
      step_nxt  = BASE_W;
      hold_nxt  = '0;
    end else begin
      continuing = (req_l && state == MOVE_L) || (req_r && state == MOVE_R);
      state_nxt  = req_l ? MOVE_L : MOVE_R;

      if (continuing) begin
        eff_step = step;
        if (hold_cnt == HOLD_LAST) begin
          step_nxt = sat_step_inc(step);
          hold_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end else begin
        eff_step = BASE_W;
        step_nxt = BASE_W;
        hold_nxt = HW'(1);
      end

      diff = {1'b0, bar_pos} - {1'b0, eff_step};
      sum  = {1'b0, bar_pos} + {1'b0, eff_step};

      if (req_l) begin
        // bar_pos < eff_step catches the borrow out of the wide subtract.
        overshoot = (bar_pos < eff_step) || (diff < MIN_E);
        pos_nxt   = diff[W-1:0];
      end else begin
        overshoot = (sum > MAX_E);
        pos_nxt   = sum[W-1:0];
      end

      if (overshoot) begin
`ifdef PADDLE_WRAP_EN
        pos_nxt  = req_l ? MAX_W : MIN_W;
`else
        pos_nxt  = req_l ? MIN_W : MAX_W;
        step_nxt = BASE_W;
        hold_nxt = '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_paddle_position_ctrl.sv
module tb_paddle_position_ctrl;

  logic       clk = 1'b0;
  logic       clr, tick, bL, bR;
  logic [6:0] bar_pos, step;
  logic       moving, at_min, at_max;

  int tests = 0;
  int fails = 0;

  paddle_position_ctrl dut (
    .clk    (clk),
    .clr    (clr),
    .tick   (tick),
    .bL     (bL),
    .bR     (bR),
    .bar_pos(bar_pos),
    .step   (step),
    .moving (moving),
    .at_min (at_min),
    .at_max (at_max)
  );

  always #5 clk = ~clk;

  // One frame tick; outputs are stable at the returning negedge.
  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 clr = 1'b1;
    #1 clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (bar_pos !== 7'd43) begin fails++; $display("FAIL reset_pos got %0d exp 43", bar_pos); end
    tests++; if (step !== 7'd2) begin fails++; $display("FAIL reset_step got %0d exp 2", step); end
    tests++; if ({moving, at_min, at_max} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {moving, at_min, at_max}); end
    clr = 1'b0;
    bR  = 1'b1;
    pulse_tick();
    bR  = 1'b0;
    tests++; if (bar_pos !== 7'd45 || moving !== 1'b1) begin fails++; $display("FAIL first_move got pos %0d mv %b exp 45 1", bar_pos, moving); end
    // Asynchronous clear between clock edges.
    #1 clr = 1'b1;
    #1;
    tests++; if (bar_pos !== 7'd43 || step !== 7'd2) begin fails++; $display("FAIL async_clr got pos %0d step %0d exp 43 2", bar_pos, step); end
    tests++; if ({moving, at_min, at_max} !== 3'b000) begin fails++; $display("FAIL async_clr_flags got %b exp 000", {moving, at_min, at_max}); end
    #1 clr = 1'b0;
  endtask

  task automatic test_hold_right();
    int exp_pos[11] = '{45, 47, 49, 51, 53, 55, 57, 59, 62, 65, 67};
    apply_reset();
    bR = 1'b1;
    for (int i = 0; i < 11; i++) begin
      pulse_tick();
      tests++; if (bar_pos !== 7'(exp_pos[i])) begin fails++; $display("FAIL hold_right_t%0d got %0d exp %0d", i + 1, bar_pos, exp_pos[i]); end
      if (i == 7) begin
        tests++; if (step !== 7'd3) begin fails++; $display("FAIL accel_step got %0d exp 3", step); end
      end
    end
    bR = 1'b0;
    tests++; if (at_max !== 1'b1 || at_min !== 1'b0) begin fails++; $display("FAIL right_wall_flags got max %b min %b exp 1 0", at_max, at_min); end
    tests++; if (step !== 7'd2 || moving !== 1'b1) begin fails++; $display("FAIL right_clamp_step got step %0d mv %b exp 2 1", step, moving); end
  endtask

  task automatic test_both_pressed();
    apply_reset();
    bL = 1'b1; bR = 1'b1;
    repeat (5) pulse_tick();
    bL = 1'b0; bR = 1'b0;
    tests++; if (bar_pos !== 7'd43 || moving !== 1'b0 || step !== 7'd2) begin fails++; $display("FAIL both_pressed got pos %0d mv %b step %0d exp 43 0 2", bar_pos, moving, step); end
  endtask

  task automatic test_reversal();
    apply_reset();
    bR = 1'b1;
    repeat (9) pulse_tick();
    tests++; if (bar_pos !== 7'd62 || step !== 7'd3) begin fails++; $display("FAIL pre_reverse got pos %0d step %0d exp 62 3", bar_pos, step); end
    bR = 1'b0; bL = 1'b1;
    pulse_tick();
    tests++; if (bar_pos !== 7'd60 || step !== 7'd2 || moving !== 1'b1) begin fails++; $display("FAIL reverse got pos %0d step %0d mv %b exp 60 2 1", bar_pos, step, moving); end
    pulse_tick();
    bL = 1'b0;
    tests++; if (bar_pos !== 7'd58) begin fails++; $display("FAIL reverse_cont got %0d exp 58", bar_pos); end
  endtask

  task automatic test_release();
    apply_reset();
    bR = 1'b1;
    repeat (9) pulse_tick();
    bR = 1'b0;
    pulse_tick();
    tests++; if (bar_pos !== 7'd62 || moving !== 1'b0 || step !== 7'd2) begin fails++; $display("FAIL release got pos %0d mv %b step %0d exp 62 0 2", bar_pos, moving, step); end
    bR = 1'b1;
    pulse_tick();
    bR = 1'b0;
    tests++; if (bar_pos !== 7'd64) begin fails++; $display("FAIL repress got %0d exp 64", bar_pos); end
  endtask

  task automatic test_tick_gate();
    apply_reset();
    bR = 1'b1;
    repeat (100) @(negedge clk);
    tests++; if (bar_pos !== 7'd43 || moving !== 1'b0) begin fails++; $display("FAIL tick_gate got pos %0d mv %b exp 43 0", bar_pos, moving); end
    pulse_tick();
    pulse_tick();
    tests++; if (bar_pos !== 7'd47) begin fails++; $display("FAIL gated_move got %0d exp 47", bar_pos); end
    #1 clr = 1'b1;
    #1;
    tests++; if (bar_pos !== 7'd43 || moving !== 1'b0 || step !== 7'd2) begin fails++; $display("FAIL clr_in_motion got pos %0d mv %b step %0d exp 43 0 2", bar_pos, moving, step); end
    #1 clr = 1'b0;
    bR = 1'b0;
  endtask

  task automatic test_left_wall();
    int exp_pos[10] = '{41, 39, 37, 35, 33, 31, 29, 27, 24, 21};
    apply_reset();
    bL = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      tests++; if (bar_pos !== 7'(exp_pos[i])) begin fails++; $display("FAIL hold_left_t%0d got %0d exp %0d", i + 1, bar_pos, exp_pos[i]); end
    end
    pulse_tick();
`ifdef PADDLE_WRAP_EN
    tests++; if (bar_pos !== 7'd67 || at_max !== 1'b1 || step !== 7'd3 || moving !== 1'b1) begin fails++; $display("FAIL left_wrap got pos %0d max %b step %0d mv %b exp 67 1 3 1", bar_pos, at_max, step, moving); end
    pulse_tick();
    tests++; if (bar_pos !== 7'd64 || step !== 7'd3) begin fails++; $display("FAIL after_wrap got pos %0d step %0d exp 64 3", bar_pos, step); end
`else
    tests++; if (bar_pos !== 7'd19 || at_min !== 1'b1 || step !== 7'd2 || moving !== 1'b1) begin fails++; $display("FAIL left_clamp got pos %0d min %b step %0d mv %b exp 19 1 2 1", bar_pos, at_min, step, moving); end
    pulse_tick();
    tests++; if (bar_pos !== 7'd19 || at_min !== 1'b1 || step !== 7'd2) begin fails++; $display("FAIL left_at_wall got pos %0d min %b step %0d exp 19 1 2", bar_pos, at_min, step); end
`endif
    bL = 1'b0;
  endtask

  task automatic test_exact_landing();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      bR = 1'b1;
      pulse_tick();
      bR = 1'b0;
      pulse_tick();
    end
    tests++; if (bar_pos !== 7'd67 || at_max !== 1'b1 || moving !== 1'b0) begin fails++; $display("FAIL exact_land got pos %0d max %b mv %b exp 67 1 0", bar_pos, at_max, moving); end
    bR = 1'b1;
    pulse_tick();
    bR = 1'b0;
`ifdef PADDLE_WRAP_EN
    tests++; if (bar_pos !== 7'd19 || at_min !== 1'b1 || at_max !== 1'b0) begin fails++; $display("FAIL right_wrap got pos %0d min %b max %b exp 19 1 0", bar_pos, at_min, at_max); end
`else
    tests++; if (bar_pos !== 7'd67 || at_max !== 1'b1 || step !== 7'd2) begin fails++; $display("FAIL push_right_wall got pos %0d max %b step %0d exp 67 1 2", bar_pos, at_max, step); end
`endif
  endtask

  initial begin
    clr  = 1'b1;
    tick = 1'b0;
    bL   = 1'b0;
    bR   = 1'b0;
    test_reset();
    test_hold_right();
    test_both_pressed();
    test_reversal();
    test_release();
    test_tick_gate();
    test_left_wall();
    test_exact_landing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
